// File: rtl/bp_stream_host_pkg.sv
// Shared types and default console/host address map for bp_stream_host.
package bp_stream_host_pkg;

  localparam int unsigned addr_width_lp = 32;
  localparam int unsigned resp_width_lp = 64;
  localparam int unsigned char_width_lp = 8;

  localparam logic [addr_width_lp-1:0] putchar_addr_gp = 32'h0010_1000;
  localparam logic [addr_width_lp-1:0] getchar_addr_gp = 32'h0010_0000;
  localparam logic [addr_width_lp-1:0] finish_addr_gp  = 32'h0010_2000;
  localparam logic [addr_width_lp-1:0] cycle_addr_gp   = 32'h0030_bff8;

  typedef enum logic [2:0] {
    e_addr,
    e_data,
    e_put,
    e_resp_lo,
    e_resp_hi
  } bp_stream_host_state_e;

endpackage

// File: rtl/bp_stream_host.sv
// Host-side command stream decoder: console putchar/getchar, finish flag and
// 64-bit cycle counter reads, with responses returned as two 32-bit words.
module bp_stream_host
  import bp_stream_host_pkg::*;
#(
  parameter int unsigned stream_data_width_p = 32,
  parameter logic [addr_width_lp-1:0] putchar_addr_p = putchar_addr_gp,
  parameter logic [addr_width_lp-1:0] getchar_addr_p = getchar_addr_gp,
  parameter logic [addr_width_lp-1:0] finish_addr_p  = finish_addr_gp,
  parameter logic [addr_width_lp-1:0] cycle_addr_p   = cycle_addr_gp
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           stream_v_i,
  input  logic [stream_data_width_p-1:0] stream_data_i,
  output logic                           stream_yumi_o,
  output logic                           stream_v_o,
  output logic [stream_data_width_p-1:0] stream_data_o,
  input  logic                           stream_ready_i,
  output logic                           char_v_o,
  output logic [char_width_lp-1:0]       char_o,
  input  logic                           char_ready_i,
  input  logic                           rx_v_i,
  input  logic [char_width_lp-1:0]       rx_data_i,
  output logic                           rx_yumi_o,
  output logic                           finish_o,
  output logic [char_width_lp-1:0]       finish_code_o
);

  bp_stream_host_state_e state_r, state_n;

  logic [addr_width_lp-1:0] addr_r;
  logic [char_width_lp-1:0] char_r;
  logic [resp_width_lp-1:0] resp_r;
  logic [resp_width_lp-1:0] counter_r;
  logic                     finish_r;
  logic [char_width_lp-1:0] finish_code_r;

  logic is_put, is_get, is_fin, is_cyc;
  logic data_accept;

  assign is_put = (addr_r == putchar_addr_p);
  assign is_get = (addr_r == getchar_addr_p);
  assign is_fin = (addr_r == finish_addr_p);
  assign is_cyc = (addr_r == cycle_addr_p);

  assign data_accept = (state_r == e_data) && stream_v_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_addr;
    else         state_r <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_addr:    if (stream_v_i) state_n = e_data;
      e_data: begin
        if (stream_v_i) begin
          if (is_put)                state_n = e_put;
          else if (is_get || is_cyc) state_n = e_resp_lo;
          else                       state_n = e_addr;
        end
      end
      e_put:     if (char_ready_i)   state_n = e_addr;
      e_resp_lo: if (stream_ready_i) state_n = e_resp_hi;
      e_resp_hi: if (stream_ready_i) state_n = e_addr;
      default:                       state_n = e_addr;
    endcase
  end

  // Handshake outputs; all forced low while reset is held
  always_comb begin
    stream_yumi_o = 1'b0;
    stream_v_o    = 1'b0;
    stream_data_o = stream_data_width_p'(resp_r[31:0]);
    char_v_o      = 1'b0;
    rx_yumi_o     = 1'b0;
    if (state_r == e_resp_hi)
      stream_data_o = stream_data_width_p'(resp_r[63:32]);
    if (!reset_i) begin
      unique case (state_r)
        e_addr:    stream_yumi_o = stream_v_i;
        e_data: begin
          stream_yumi_o = stream_v_i;
          rx_yumi_o     = stream_v_i && is_get && rx_v_i;
        end
        e_put:     char_v_o   = 1'b1;
        e_resp_lo: stream_v_o = 1'b1;
        e_resp_hi: stream_v_o = 1'b1;
        default: ;
      endcase
    end
  end

  // Datapath: address/char/response capture, finish flag and free-running counter
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_r        <= '0;
      char_r        <= '0;
      resp_r        <= '0;
      counter_r     <= '0;
      finish_r      <= 1'b0;
      finish_code_r <= '0;
    end else begin
      counter_r <= counter_r + resp_width_lp'(1);
      if (state_r == e_addr && stream_v_i)
        addr_r <= addr_width_lp'(stream_data_i);
      if (data_accept) begin
        if (is_put)
          char_r <= stream_data_i[char_width_lp-1:0];
        if (is_fin) begin
          finish_r      <= 1'b1;
          finish_code_r <= stream_data_i[char_width_lp-1:0];
        end
        if (is_get)
          resp_r <= rx_v_i ? {56'b0, rx_data_i} : {resp_width_lp{1'b1}};
        if (is_cyc)
          resp_r <= counter_r;
      end
    end
  end

  assign char_o        = char_r;
  assign finish_o      = finish_r;
  assign finish_code_o = finish_code_r;

endmodule

// File: tb/tb_bp_stream_host.sv
// Directed self-checking bench for bp_stream_host.
module tb_bp_stream_host;
  import bp_stream_host_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        stream_v_i;
  logic [31:0] stream_data_i;
  logic        stream_yumi_o;
  logic        stream_v_o;
  logic [31:0] stream_data_o;
  logic        stream_ready_i;
  logic        char_v_o;
  logic [7:0]  char_o;
  logic        char_ready_i;
  logic        rx_v_i;
  logic [7:0]  rx_data_i;
  logic        rx_yumi_o;
  logic        finish_o;
  logic [7:0]  finish_code_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int char_xfers   = 0;
  int rx_pulses    = 0;
  logic [63:0] tb_cnt;
  logic [63:0] exp_cnt;

  bp_stream_host dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .stream_v_i    (stream_v_i),
    .stream_data_i (stream_data_i),
    .stream_yumi_o (stream_yumi_o),
    .stream_v_o    (stream_v_o),
    .stream_data_o (stream_data_o),
    .stream_ready_i(stream_ready_i),
    .char_v_o      (char_v_o),
    .char_o        (char_o),
    .char_ready_i  (char_ready_i),
    .rx_v_i        (rx_v_i),
    .rx_data_i     (rx_data_i),
    .rx_yumi_o     (rx_yumi_o),
    .finish_o      (finish_o),
    .finish_code_o (finish_code_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference cycle counter and handshake event counters
  always @(posedge clk_i) begin
    if (reset_i) tb_cnt <= 64'd0;
    else         tb_cnt <= tb_cnt + 64'd1;
    if (char_v_o && char_ready_i) char_xfers <= char_xfers + 1;
    if (rx_yumi_o) rx_pulses <= rx_pulses + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input string tag);
    stream_v_i    = 1'b1;
    stream_data_i = w;
    #1;
    chk(tag, 64'(stream_yumi_o), 64'd1);
    tick();
    stream_v_i = 1'b0;
  endtask

  initial begin
    reset_i        = 1'b1;
    stream_v_i     = 1'b1;
    stream_data_i  = 32'h0;
    stream_ready_i = 1'b0;
    char_ready_i   = 1'b0;
    rx_v_i         = 1'b1;
    rx_data_i      = 8'h00;

    // Reset state with valid inputs offered
    tick(); tick();
    chk("rst_yumi", 64'(stream_yumi_o), 64'd0);
    chk("rst_sv", 64'(stream_v_o), 64'd0);
    chk("rst_cv", 64'(char_v_o), 64'd0);
    chk("rst_rxy", 64'(rx_yumi_o), 64'd0);
    chk("rst_fin", 64'(finish_o), 64'd0);
    chk("rst_code", 64'(finish_code_o), 64'd0);
    reset_i    = 1'b0;
    stream_v_i = 1'b0;
    rx_v_i     = 1'b0;
    tick();

    // Putchar 'A' with sink stalled 3 cycles; next address offered throughout
    send(putchar_addr_gp, "put_addr");
    send(32'h0000_0041, "put_data");
    stream_v_i    = 1'b1;
    stream_data_i = getchar_addr_gp;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("put_cv_stall", 64'(char_v_o), 64'd1);
      chk("put_char_stall", 64'(char_o), 64'h41);
      chk("put_yumi0", 64'(stream_yumi_o), 64'd0);
      chk("put_sv0", 64'(stream_v_o), 64'd0);
      tick();
    end
    char_ready_i = 1'b1;
    #1;
    chk("put_cv_xfer", 64'(char_v_o), 64'd1);
    tick();
    char_ready_i = 1'b0;
    #1;
    chk("put_done_cv", 64'(char_v_o), 64'd0);
    chk("put_xfers", 64'(char_xfers), 64'd1);
    chk("next_addr_yumi", 64'(stream_yumi_o), 64'd1);
    tick();

    // Getchar with a character available
    stream_data_i = 32'h0;
    rx_v_i        = 1'b1;
    rx_data_i     = 8'h5A;
    #1;
    chk("get_data_yumi", 64'(stream_yumi_o), 64'd1);
    chk("get_rxy", 64'(rx_yumi_o), 64'd1);
    tick();
    stream_v_i     = 1'b0;
    stream_ready_i = 1'b1;
    #1;
    chk("get_lo_v", 64'(stream_v_o), 64'd1);
    chk("get_lo", 64'(stream_data_o), 64'h5A);
    chk("get_rxy_lo0", 64'(rx_yumi_o), 64'd0);
    tick();
    #1;
    chk("get_hi_v", 64'(stream_v_o), 64'd1);
    chk("get_hi", 64'(stream_data_o), 64'h0);
    tick();
    rx_v_i = 1'b0;
    #1;
    chk("get_end_v", 64'(stream_v_o), 64'd0);
    chk("get_rx_pulses", 64'(rx_pulses), 64'd1);

    // Getchar with nothing available
    send(getchar_addr_gp, "gete_addr");
    stream_v_i = 1'b1;
    stream_data_i = 32'h0;
    #1;
    chk("gete_rxy0", 64'(rx_yumi_o), 64'd0);
    tick();
    stream_v_i = 1'b0;
    #1;
    chk("gete_lo", 64'(stream_data_o), 64'hFFFF_FFFF);
    tick();
    #1;
    chk("gete_hi", 64'(stream_data_o), 64'hFFFF_FFFF);
    tick();
    chk("gete_rx_pulses", 64'(rx_pulses), 64'd1);

    // Cycle read with 5-cycle stall per word
    send(cycle_addr_gp, "cyc_addr");
    stream_ready_i = 1'b0;
    stream_v_i     = 1'b1;
    stream_data_i  = 32'h0;
    #1;
    exp_cnt = tb_cnt;
    chk("cyc_data_yumi", 64'(stream_yumi_o), 64'd1);
    tick();
    stream_v_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("cyc_lo_stall", 64'(stream_data_o), 64'(exp_cnt[31:0]));
      chk("cyc_lo_v", 64'(stream_v_o), 64'd1);
      tick();
    end
    stream_ready_i = 1'b1;
    #1;
    chk("cyc_lo", 64'(stream_data_o), 64'(exp_cnt[31:0]));
    tick();
    stream_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("cyc_hi_stall", 64'(stream_data_o), 64'(exp_cnt[63:32]));
      tick();
    end
    stream_ready_i = 1'b1;
    #1;
    chk("cyc_hi", 64'(stream_data_o), 64'(exp_cnt[63:32]));
    tick();

    // Finish, sticky across an unmapped write, code updated by a later finish
    send(finish_addr_gp, "fin_addr");
    send(32'h0000_0003, "fin_data");
    chk("fin_flag", 64'(finish_o), 64'd1);
    chk("fin_code", 64'(finish_code_o), 64'd3);
    send(32'h0020_0000, "unm_addr");
    send(32'h0000_00EE, "unm_data");
    stream_v_i = 1'b1;
    #1;
    chk("unm_back_addr", 64'(stream_yumi_o), 64'd1);
    chk("unm_sv0", 64'(stream_v_o), 64'd0);
    chk("unm_cv0", 64'(char_v_o), 64'd0);
    stream_v_i = 1'b0;
    chk("fin_sticky", 64'(finish_o), 64'd1);
    chk("fin_code_keep", 64'(finish_code_o), 64'd3);
    send(finish_addr_gp, "fin2_addr");
    send(32'h0000_0007, "fin2_data");
    chk("fin2_code", 64'(finish_code_o), 64'd7);

    // Reset while in the high response word
    send(getchar_addr_gp, "rr_addr");
    send(32'h0, "rr_data");
    #1;
    chk("rr_lo", 64'(stream_data_o), 64'hFFFF_FFFF);
    tick();
    stream_ready_i = 1'b0;
    #1;
    chk("rr_hi_v", 64'(stream_v_o), 64'd1);
    reset_i = 1'b1;
    #1;
    chk("rr_in_rst_v", 64'(stream_v_o), 64'd0);
    tick();
    reset_i = 1'b0;
    #1;
    chk("rr_after_v", 64'(stream_v_o), 64'd0);
    chk("rr_fin_clr", 64'(finish_o), 64'd0);
    chk("rr_code_clr", 64'(finish_code_o), 64'd0);
    stream_ready_i = 1'b1;
    send(putchar_addr_gp, "rr_put_addr");
    send(32'h0000_0042, "rr_put_data");
    char_ready_i = 1'b1;
    #1;
    chk("rr_put_cv", 64'(char_v_o), 64'd1);
    chk("rr_put_char", 64'(char_o), 64'h42);
    chk("rr_put_sv0", 64'(stream_v_o), 64'd0);
    tick();
    #1;
    chk("rr_put_done", 64'(char_v_o), 64'd0);
    chk("rr_put_xfers", 64'(char_xfers), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
